// File: rtl/router_ctrl.sv
// router_ctrl: packet-level controller for the 1x3 router.
// Decodes {len[7:2], addr[1:0]} headers, steers bytes to one of three FIFOs,
// back-pressures the source via busy, and flushes FIFOs whose readers stall.
// Optional build macro: PARITY_CHECK_EN (enables the parity register, the
// compare and the err flag; when undefined err is tied low).
module router_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 30,
  parameter int TO_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            fifo_full,
  input  logic [2:0]            fifo_empty,
  input  logic [2:0]            read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            write_enb,
  output logic                  busy,
  output logic [2:0]            vld_out,
  output logic [2:0]            soft_reset,
  output logic                  err,
  output logic                  drop
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] WAIT_EMPTY  = 3'd1;
  localparam logic [2:0] LOAD_DATA   = 3'd2;
  localparam logic [2:0] LOAD_PARITY = 3'd3;
  localparam logic [2:0] CHECK       = 3'd4;
  localparam logic [2:0] DROP        = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [DATA_WIDTH-1:0]      hdr_q, hdr_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [6:0]                 rem_q, rem_d;
  logic [DATA_WIDTH-1:0]      data_out_q, data_out_d;
  logic [2:0]                 write_enb_q, write_enb_d;
  logic                       drop_q, drop_d;
  logic [2:0]                 soft_reset_q, soft_reset_d;
  logic [2:0][TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
`ifdef PARITY_CHECK_EN
  logic [DATA_WIDTH-1:0]      parity_q, parity_d;
  logic [DATA_WIDTH-1:0]      rx_parity_q, rx_parity_d;
  logic                       err_q, err_d;
`endif

  logic [1:0] addr;
  logic [1:0] hdr_addr_in;
  logic [3:0] full_ext, empty_ext, sr_ext;
  logic       accept;
  logic [6:0] abort_rem;

  // Port 3 has no FIFO; padding to 4 bits keeps the address-indexed lookups in range.
  assign addr        = hdr_q[1:0];
  assign hdr_addr_in = data_in[1:0];
  assign full_ext    = {1'b0, fifo_full};
  assign empty_ext   = {1'b0, fifo_empty};
  assign sr_ext      = {1'b0, soft_reset_q};
  assign accept      = pkt_valid & ~busy;

  function automatic logic [2:0] port_sel(input logic [1:0] a);
    case (a)
      2'd0:    port_sel = 3'b001;
      2'd1:    port_sel = 3'b010;
      2'd2:    port_sel = 3'b100;
      default: port_sel = 3'b000;
    endcase
  endfunction

  // Source back-pressure, combinational on the current FIFO full flag.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      WAIT_EMPTY:             busy = 1'b1;
      LOAD_DATA, LOAD_PARITY: busy = full_ext[addr];
      CHECK:                  busy = 1'b1;
      default:                busy = 1'b0;
    endcase
  end

  // Packet FSM: header decode, byte steering, parity check, drop/abort handling.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    data_out_d  = data_out_q;
    write_enb_d = '0;
    drop_d      = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_d    = parity_q;
    rx_parity_d = rx_parity_q;
    err_d       = err_q;
`endif
    // Bytes still owed by the source if the packet is aborted now, parity included;
    // a byte accepted in the abort cycle itself is already consumed.
    abort_rem   = (state_q == LOAD_PARITY) ? 7'd1 : ({1'b0, cnt_q} + 7'd1);
    abort_rem   = abort_rem - {6'd0, accept};

    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          hdr_d = data_in;
          cnt_d = data_in[7:2];
`ifdef PARITY_CHECK_EN
          parity_d = data_in;
          err_d    = 1'b0;
`endif
          if (hdr_addr_in == 2'd3) begin
            rem_d   = {1'b0, data_in[7:2]} + 7'd1;
            state_d = DROP;
          end else if (empty_ext[hdr_addr_in]) begin
            data_out_d  = data_in;
            write_enb_d = port_sel(hdr_addr_in);
            state_d     = (data_in[7:2] == 6'd0) ? LOAD_PARITY : LOAD_DATA;
          end else begin
            state_d = WAIT_EMPTY;
          end
        end
      end
      WAIT_EMPTY: begin
        if (empty_ext[addr]) begin
          data_out_d  = hdr_q;
          write_enb_d = port_sel(addr);
          state_d     = (cnt_q == 6'd0) ? LOAD_PARITY : LOAD_DATA;
        end
      end
      LOAD_DATA, LOAD_PARITY: begin
        if (sr_ext[addr]) begin
          // Flushed mid-packet: swallow the rest of the packet without writing.
          if (abort_rem == 7'd0) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d   = abort_rem;
            state_d = DROP;
          end
        end else if (accept) begin
          data_out_d  = data_in;
          write_enb_d = port_sel(addr);
          if (state_q == LOAD_DATA) begin
`ifdef PARITY_CHECK_EN
            parity_d = parity_q ^ data_in;
`endif
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = LOAD_PARITY;
          end else begin
`ifdef PARITY_CHECK_EN
            rx_parity_d = data_in;
`endif
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
`ifdef PARITY_CHECK_EN
        err_d = (parity_q != rx_parity_q);
`endif
        state_d = IDLE;
      end
      DROP: begin
        if (accept) begin
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-port reader stall timers; each fires a one-cycle flush pulse.
  always_comb begin
    to_cnt_d     = to_cnt_q;
    soft_reset_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!fifo_empty[i] && !read_enb[i]) begin
        if (to_cnt_q[i] == TO_WIDTH'(TIMEOUT - 1)) begin
          soft_reset_d[i] = 1'b1;
          to_cnt_d[i]     = '0;
        end else begin
          to_cnt_d[i] = to_cnt_q[i] + TO_WIDTH'(1);
        end
      end else begin
        to_cnt_d[i] = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      hdr_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      data_out_q   <= '0;
      write_enb_q  <= '0;
      drop_q       <= 1'b0;
      soft_reset_q <= '0;
      to_cnt_q     <= '0;
`ifdef PARITY_CHECK_EN
      parity_q     <= '0;
      rx_parity_q  <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      data_out_q   <= data_out_d;
      write_enb_q  <= write_enb_d;
      drop_q       <= drop_d;
      soft_reset_q <= soft_reset_d;
      to_cnt_q     <= to_cnt_d;
`ifdef PARITY_CHECK_EN
      parity_q     <= parity_d;
      rx_parity_q  <= rx_parity_d;
      err_q        <= err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign write_enb  = write_enb_q;
  assign drop       = drop_q;
  assign soft_reset = soft_reset_q;
  assign vld_out    = ~fifo_empty;
`ifdef PARITY_CHECK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: expected FIFO writes are queued as bytes are accepted
// and compared in order whenever the DUT raises write_enb.
module tb_router_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [7:0] data_out;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       busy, err, drop;

`ifdef PARITY_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  router_ctrl #(.DATA_WIDTH(8), .TIMEOUT(30), .TO_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .data_out(data_out), .write_enb(write_enb), .busy(busy), .vld_out(vld_out),
    .soft_reset(soft_reset), .err(err), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && write_enb !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {21'd0, write_enb, data_out}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("fifo_write", {21'd0, write_enb, data_out}, {21'd0, mon_exp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, wait for an accept (bounded), queue its expected write.
  task automatic send_byte(input logic [7:0] b, input logic wr, input logic [2:0] wen);
    bit ok = 1'b0;
    pkt_valid = 1'b1;
    data_in   = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("accept", {31'd0, ok}, 32'd1);
    if (ok && wr) exp_q.push_back({wen, b});
    step();
    pkt_valid = 1'b0;
  endtask

  // Whole packet with payload bytes 11,22,33...; optionally corrupt parity.
  task automatic send_pkt(input logic [7:0] hdr, input logic bad);
    logic [7:0] par, b;
    logic [1:0] a;
    logic [2:0] wen;
    int         len;
    a   = hdr[1:0];
    len = int'(hdr[7:2]);
    wen = (a == 2'd3) ? 3'b000 : 3'(3'b001 << a);
    par = hdr;
    send_byte(hdr, a != 2'd3, wen);
    for (int k = 0; k < len; k++) begin
      b   = 8'(8'h11 * (k + 1));
      par = par ^ b;
      send_byte(b, a != 2'd3, wen);
    end
    send_byte(bad ? ~par : par, a != 2'd3, wen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0;
    fifo_full = '0; fifo_empty = 3'b111; read_enb = '0;

    // Reset values
    @(negedge clk);
    check_eq("rst_outputs", {16'd0, data_out, write_enb, soft_reset, err, drop},
             32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Good packet to port 1: 5 writes, busy only in CHECK, err clear
    send_pkt(8'h0D, 1'b0);
    @(negedge clk);
    check_eq("check_busy", {31'd0, busy}, 32'd1);
    step();
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("err_good", {31'd0, err}, 32'd0);
    step();

    // Corrupted parity
    send_pkt(8'h0D, 1'b1);
    step();
    @(negedge clk);
    check_eq("err_bad", {31'd0, err}, {31'd0, EXP_ERR});
    step();

    // Address 3: len 2 -> three more bytes swallowed, one drop pulse
    send_byte(8'h0B, 1'b0, 3'b000);
    @(negedge clk);
    check_eq("err_cleared", {31'd0, err}, 32'd0);
    step();
    send_byte(8'hAA, 1'b0, 3'b000);
    send_byte(8'hBB, 1'b0, 3'b000);
    @(negedge clk);
    check_eq("drop_early", {31'd0, drop}, 32'd0);
    step();
    send_byte(8'hCC, 1'b0, 3'b000);
    @(negedge clk);
    check_eq("drop_pulse", {31'd0, drop}, 32'd1);
    step();
    @(negedge clk);
    check_eq("drop_single", {31'd0, drop}, 32'd0);
    step();

    // FIFO0 not empty at header -> WAIT_EMPTY until released
    fifo_empty = 3'b110;
    send_byte(8'h04, 1'b1, 3'b001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("wait_busy", {31'd0, busy}, 32'd1);
      step();
    end
    @(negedge clk);
    check_eq("vld_out", {29'd0, vld_out}, 32'd1);
    step();
    fifo_empty = 3'b111;
    send_byte(8'h5A, 1'b1, 3'b001);
    send_byte(8'h04 ^ 8'h5A, 1'b1, 3'b001);

    // FIFO2 full for 4 cycles in mid-payload
    send_byte(8'h0E, 1'b1, 3'b100);
    send_byte(8'h11, 1'b1, 3'b100);
    fifo_full = 3'b100; pkt_valid = 1'b1; data_in = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("full_busy", {31'd0, busy}, 32'd1);
      step();
    end
    fifo_full = '0;
    send_byte(8'h22, 1'b1, 3'b100);
    send_byte(8'h33, 1'b1, 3'b100);
    send_byte(8'h0E ^ 8'h11 ^ 8'h22 ^ 8'h33, 1'b1, 3'b100);
    step(); step();

    // FIFO1 stalled: pulse on cycle 31, single cycle
    fifo_empty = 3'b101;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (soft_reset != 3'b000) seen = 1'b1;
      step();
    end
    check_eq("sr_early", {31'd0, seen}, 32'd0);
    @(negedge clk);
    check_eq("sr_pulse", {29'd0, soft_reset}, 32'd2);
    step();
    @(negedge clk);
    check_eq("sr_single", {29'd0, soft_reset}, 32'd0);
    step();
    fifo_empty = 3'b111;
    step();

    // Timeout mid-packet to port 1: abort, 4 bytes swallowed, drop
    send_byte(8'h11, 1'b1, 3'b010);
    fifo_empty = 3'b101;
    send_byte(8'hA1, 1'b1, 3'b010);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (soft_reset[1]) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq("abort_sr", {31'd0, seen}, 32'd1);
    step();
    fifo_empty = 3'b111;
    send_byte(8'hE1, 1'b0, 3'b000);
    send_byte(8'hE2, 1'b0, 3'b000);
    send_byte(8'hE3, 1'b0, 3'b000);
    @(negedge clk);
    check_eq("abort_drop_early", {31'd0, drop}, 32'd0);
    step();
    send_byte(8'hE4, 1'b0, 3'b000);
    @(negedge clk);
    check_eq("abort_drop", {31'd0, drop}, 32'd1);
    step();

    // Async reset mid-packet, then a zero-length packet from clean IDLE
    send_byte(8'h08, 1'b1, 3'b001);
    send_byte(8'h77, 1'b1, 3'b001);
    step();
    resetn = 1'b0;
    @(negedge clk);
    check_eq("midrst_wen", {29'd0, write_enb}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    step();
    resetn = 1'b1;
    step();
    send_pkt(8'h00, 1'b0);
    step(); step(); step();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
